// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM state encodings and default bus widths.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

    localparam int AMBA_WORD_DEFAULT       = 32;
    localparam int AMBA_ADDR_WIDTH_DEFAULT = 20;

endpackage

// File: rtl/apb_master_fsm.sv
// APB requester state register and next-state logic (IDLE -> SETUP -> ACCESS).
module apb_master_fsm
    import apb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic       pready,
    input  logic       timeout,
    output apb_state_t state
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= cmd_valid ? SETUP : IDLE;
                SETUP:   state <= ACCESS;
                ACCESS: begin
                    // A completing transfer chains straight into SETUP when a new command waits.
                    if (pready)
                        state <= cmd_valid ? SETUP : IDLE;
                    else if (timeout)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB3 requester: valid/ready command stream in, APB transfers out, one-cycle response strobe.
// Optional ACCESS-phase abort counter enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int AMBA_WORD       = AMBA_WORD_DEFAULT,
    parameter int AMBA_ADDR_WIDTH = AMBA_ADDR_WIDTH_DEFAULT,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic                       rsp_err,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic [AMBA_WORD-1:0]       PRDATA,
    input  logic                       PREADY,
    input  logic                       PSLVERR
);

    apb_state_t state;
    logic       complete;
    logic       accept;
    logic       timeout;

    assign complete  = (state == ACCESS) && PREADY;
    assign cmd_ready = (state == IDLE) || complete;
    assign accept    = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt;

    // Counts wait states of the current ACCESS phase; any other state clears it.
    always_ff @(posedge clk) begin
        if (!rst)
            wait_cnt <= '0;
        else if (state != ACCESS)
            wait_cnt <= '0;
        else if (!PREADY)
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout = (state == ACCESS) && !PREADY &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    apb_master_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .pready    (PREADY),
        .timeout   (timeout),
        .state     (state)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= complete || timeout;
            rsp_err   <= complete ? PSLVERR : timeout;
            rsp_rdata <= (complete && !PWRITE) ? PRDATA : '0;

            if (accept) begin
                PWRITE  <= cmd_write;
                PADDR   <= cmd_addr;
                PWDATA  <= cmd_wdata;
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
            end else begin
                case (state)
                    SETUP:   PENABLE <= 1'b1;
                    ACCESS: begin
                        if (complete || timeout) begin
                            PSEL    <= 1'b0;
                            PENABLE <= 1'b0;
                        end
                    end
                    IDLE: begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                    end
                    default: begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: bench plays the APB completer and predicts responses from the transfer rules.
module tb_apb_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [19:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [19:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int total = 0;
    int bad   = 0;

    apb_master #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one complete transfer from IDLE as the completer and reports what was observed.
    task automatic do_xfer(input logic w, input logic [19:0] a, input logic [31:0] d,
                           input int waits, input logic [31:0] rd, input logic er,
                           output logic acc_ok, output logic ph_ok, output logic hold_ok,
                           output logic rv, output logic re, output logic [31:0] rdo,
                           output logic after_ok);
        acc_ok    = (cmd_ready === 1'b1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        step();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 20'($urandom);
        cmd_wdata = $urandom;
        ph_ok = (PSEL === 1'b1) && (PENABLE === 1'b0) && (PADDR === a) &&
                (PWRITE === w) && (PWDATA === d) && (cmd_ready === 1'b0);
        step();
        ph_ok = ph_ok && (PSEL === 1'b1) && (PENABLE === 1'b1);
        hold_ok = 1'b1;
        for (int i = 0; i < waits; i++) begin
            PREADY  = 1'b0;
            PSLVERR = 1'b1;
            hold_ok = hold_ok && (cmd_ready === 1'b0);
            step();
            hold_ok = hold_ok && (PSEL === 1'b1) && (PENABLE === 1'b1) && (PADDR === a) &&
                      (PWRITE === w) && (PWDATA === d) && (rsp_valid === 1'b0);
        end
        PREADY  = 1'b1;
        PRDATA  = rd;
        PSLVERR = er;
        step();
        rv  = rsp_valid;
        re  = rsp_err;
        rdo = rsp_rdata;
        hold_ok = hold_ok && (PSEL === 1'b0) && (PENABLE === 1'b0);
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = $urandom;
        step();
        after_ok = (rsp_valid === 1'b0) && (PSEL === 1'b0) && (PADDR === a) &&
                   (PWDATA === d) && (PWRITE === w);
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        step();
        step();
        total++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin bad++; $display("FAIL reset_ctrl got=%b want=000", {PSEL, PENABLE, PWRITE}); end
        total++; if (PADDR !== 20'h0 || PWDATA !== 32'h0) begin bad++; $display("FAIL reset_bus got=%h/%h want=0/0", PADDR, PWDATA); end
        total++; if ({rsp_valid, rsp_err} !== 2'b00 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp got=%b%b/%h want=00/0", rsp_valid, rsp_err, rsp_rdata); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_write_zero_wait();
        logic acc, ph, hold, rv, re, aft;
        logic [31:0] rdo;
        do_xfer(1'b1, 20'h00010, 32'hDEADBEEF, 0, 32'hCAFEF00D, 1'b0, acc, ph, hold, rv, re, rdo, aft);
        total++; if ({acc, ph, hold} !== 3'b111) begin bad++; $display("FAIL wr0_phases got=%b want=111", {acc, ph, hold}); end
        total++; if ({rv, re} !== 2'b10 || rdo !== 32'h0) begin bad++; $display("FAIL wr0_rsp got=%b%b/%h want=10/00000000", rv, re, rdo); end
        total++; if (aft !== 1'b1) begin bad++; $display("FAIL wr0_after got=%b want=1", aft); end
    endtask

    task automatic test_read_wait();
        logic acc, ph, hold, rv, re, aft;
        logic [31:0] rdo;
        do_xfer(1'b0, 20'h00400, 32'h0BADF00D, 3, 32'h12345678, 1'b0, acc, ph, hold, rv, re, rdo, aft);
        total++; if ({acc, ph, hold} !== 3'b111) begin bad++; $display("FAIL rd3_phases got=%b want=111", {acc, ph, hold}); end
        total++; if ({rv, re} !== 2'b10 || rdo !== 32'h12345678) begin bad++; $display("FAIL rd3_rsp got=%b%b/%h want=10/12345678", rv, re, rdo); end
        total++; if (aft !== 1'b1) begin bad++; $display("FAIL rd3_after got=%b want=1", aft); end
    endtask

    task automatic test_error();
        logic acc, ph, hold, rv, re, aft;
        logic [31:0] rdo;
        do_xfer(1'b0, 20'h00ABC, 32'h0, 2, 32'hA5A5A5A5, 1'b1, acc, ph, hold, rv, re, rdo, aft);
        total++; if (hold !== 1'b1) begin bad++; $display("FAIL err_waits got=%b want=1", hold); end
        total++; if ({rv, re} !== 2'b11 || rdo !== 32'hA5A5A5A5) begin bad++; $display("FAIL err_rsp got=%b%b/%h want=11/a5a5a5a5", rv, re, rdo); end
    endtask

    task automatic test_back_to_back();
        logic ok;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'h00020; cmd_wdata = 32'h11112222;
        PREADY = 1'b1; PSLVERR = 1'b0;
        step();
        cmd_write = 1'b0; cmd_addr = 20'h00030; cmd_wdata = 32'h0;
        ok = (PSEL === 1'b1) && (PENABLE === 1'b0) && (cmd_ready === 1'b0);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_setup1 got=%b%b rdy=%b want=10 rdy=0", PSEL, PENABLE, cmd_ready); end
        step();
        total++; if (cmd_ready !== 1'b1 || PENABLE !== 1'b1) begin bad++; $display("FAIL b2b_access1 got rdy=%b en=%b want 1/1", cmd_ready, PENABLE); end
        step();
        cmd_valid = 1'b0; PRDATA = 32'h87654321;
        ok = (rsp_valid === 1'b1) && (rsp_rdata === 32'h0) && (PSEL === 1'b1) && (PENABLE === 1'b0) &&
             (PADDR === 20'h00030) && (PWRITE === 1'b0);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_chain got v=%b sel=%b en=%b addr=%h want 1/1/0/00030", rsp_valid, PSEL, PENABLE, PADDR); end
        step();
        total++; if (rsp_valid !== 1'b0 || PSEL !== 1'b1 || PENABLE !== 1'b1) begin bad++; $display("FAIL b2b_access2 got v=%b sel=%b en=%b want 0/1/1", rsp_valid, PSEL, PENABLE); end
        step();
        total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h87654321 || PSEL !== 1'b0) begin bad++; $display("FAIL b2b_rsp2 got v=%b d=%h sel=%b want 1/87654321/0", rsp_valid, rsp_rdata, PSEL); end
        PREADY = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic acc, ph, hold, rv, re, aft;
        logic [31:0] rdo;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00777; PREADY = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        total++; if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin bad++; $display("FAIL rstmid_drop got=%b want=000", {PSEL, PENABLE, rsp_valid}); end
        rst = 1'b1;
        step();
        total++; if ({PSEL, rsp_valid, cmd_ready} !== 3'b001) begin bad++; $display("FAIL rstmid_idle got=%b want=001", {PSEL, rsp_valid, cmd_ready}); end
        do_xfer(1'b1, 20'h00900, 32'h01020304, 1, 32'hFFFFFFFF, 1'b0, acc, ph, hold, rv, re, rdo, aft);
        total++; if ({acc, ph, hold, rv, re, aft} !== 6'b111101 || rdo !== 32'h0) begin bad++; $display("FAIL rstmid_next got=%b/%h want=111101/0", {acc, ph, hold, rv, re, aft}, rdo); end
    endtask

    // Random transfers; the completer acts as a word memory and the response is predicted from it.
    task automatic test_random();
        logic [31:0] mem [0:15];
        logic acc, ph, hold, rv, re, aft, w, er;
        logic [31:0] rdo, d, exp_d;
        logic [19:0] a;
        int waits;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int n = 0; n < 24; n++) begin
            w = 1'($urandom);
            a = 20'($urandom_range(0, 15));
            d = $urandom;
            waits = $urandom_range(0, 4);
            er = ($urandom_range(0, 3) == 0);
            exp_d = w ? 32'h0 : mem[a[3:0]];
            do_xfer(w, a, d, waits, mem[a[3:0]], er, acc, ph, hold, rv, re, rdo, aft);
            if (w) mem[a[3:0]] = d;
            total++; if ({acc, ph, hold, aft} !== 4'b1111) begin bad++; $display("FAIL rand_seq n=%0d got=%b want=1111", n, {acc, ph, hold, aft}); end
            total++; if (rv !== 1'b1 || re !== er || rdo !== exp_d) begin bad++; $display("FAIL rand_rsp n=%0d got=%b%b/%h want=1%b/%h", n, rv, re, rdo, er, exp_d); end
        end
    endtask

    task automatic test_timeout();
        int n;
        logic rdy;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00ABC; PREADY = 1'b0; PSLVERR = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        n = 1;
        rdy = 1'bx;
        while (PSEL === 1'b1 && n <= 100) begin
            if (n == TO) rdy = cmd_ready;
            step();
            n++;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        total++; if (n - 1 != TO) begin bad++; $display("FAIL to_cycles got=%0d want=%0d", n - 1, TO); end
        total++; if ({rsp_valid, rsp_err, PSEL, PENABLE} !== 4'b1100 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_rsp got=%b/%h want=1100/0", {rsp_valid, rsp_err, PSEL, PENABLE}, rsp_rdata); end
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL to_ready got=%b want=0", rdy); end
        step();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL to_after got=%b want=0", rsp_valid); end
`else
        total++; if (n != 101 || PSEL !== 1'b1 || PENABLE !== 1'b1) begin bad++; $display("FAIL to_wait got n=%0d sel=%b en=%b want 101/1/1", n, PSEL, PENABLE); end
        PREADY = 1'b1; PRDATA = 32'h55AA55AA;
        step();
        PREADY = 1'b0;
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h55AA55AA) begin bad++; $display("FAIL to_late got=%b%b/%h want=10/55aa55aa", rsp_valid, rsp_err, rsp_rdata); end
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_back_to_back();
        test_error();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
APB requester, the initiator end of the APB link the team's slave FSM responds to. Converts a simple valid/ready command stream from the system core into APB3 transfers on PSEL/PENABLE/PADDR/PWRITE/PWDATA. Samples PRDATA/PSLVERR on PREADY completion and returns a one-cycle response. One transfer in flight at a time; back-to-back transfers are supported without an IDLE bubble.

Parameters:
AMBA_WORD, 32, data bus width (PWDATA, PRDATA, cmd_wdata, rsp_rdata).
AMBA_ADDR_WIDTH, 20, address width (PADDR, cmd_addr).
TIMEOUT_CYCLES, 16, ACCESS cycles allowed before abort; used only with APB_MASTER_TIMEOUT_EN.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset, synchronous, active-low.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
cmd_write  in  1  1=write, 0=read.
cmd_addr  in  AMBA_ADDR_WIDTH  transfer address.
cmd_wdata  in  AMBA_WORD  write data.
rsp_valid  out  1  one-cycle response strobe.
rsp_rdata  out  AMBA_WORD  read data; 0 for writes.
rsp_err  out  1  PSLVERR, or timeout abort.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PADDR  out  AMBA_ADDR_WIDTH  APB address.
PWDATA  out  AMBA_WORD  APB write data.
PRDATA  in  AMBA_WORD  APB read data.
PREADY  in  1  slave ready / wait-state extend.
PSLVERR  in  1  slave error, valid with PREADY in ACCESS.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; PSEL=PENABLE=PWRITE=0; PADDR=PWDATA=0; rsp_valid=rsp_err=0; rsp_rdata=0; timeout counter=0. Reset mid-transfer drops PSEL/PENABLE on the next edge, and no response is issued.
- States: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10. 2'b11 is illegal and recovers to IDLE.
- cmd_ready = (state==IDLE) | (state==ACCESS & PREADY). It is combinational and never asserted in SETUP.
- IDLE: when cmd_valid, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP (PSEL=1, PENABLE=0).
- SETUP: always go to ACCESS after exactly one cycle (PENABLE=1).
- ACCESS, PREADY=0: hold all APB outputs stable (wait state).
- ACCESS, PREADY=1: complete the transfer. Next cycle, rsp_valid=1, rsp_err=PSLVERR, rsp_rdata=PWRITE?0:PRDATA.
  - If cmd_valid in the same cycle: latch the new command and go to SETUP. PSEL stays 1, PENABLE drops to 0.
  - Otherwise: go to IDLE, PSEL=0, PENABLE=0.
- Latency: command accept to PSEL is 1 cycle. Zero-wait transfer: accept to rsp_valid is 3 cycles.
- PADDR/PWDATA/PWRITE change only when a command is accepted. They hold their value in IDLE.
- rsp_valid is never asserted for two consecutive cycles unless two transfers complete back-to-back. There is no response backpressure.
- PSLVERR is ignored outside completion cycles.

Optional Feature:
APB_MASTER_TIMEOUT_EN.
- Defined: the counter increments each ACCESS cycle with PREADY=0 and clears on entering SETUP. When the count reaches TIMEOUT_CYCLES-1 and PREADY is still 0:
  - abort: go to IDLE, drop PSEL/PENABLE;
  - next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0;
  - cmd_ready stays 0 during the abort cycle.
- Undefined: no counter; the requester waits indefinitely for PREADY.

Decomposition:
- Shared package apb_pkg holds:
  - state encodings IDLE/SETUP/ACCESS;
  - default AMBA_WORD/AMBA_ADDR_WIDTH constants.
- One sub-module, apb_master_fsm: state register plus next-state logic (inputs cmd_valid, PREADY, timeout; output state).
- The top level holds the command/response registers and the APB output drive.

Test Plan:
1. Write, zero wait: cmd addr=0x00010, wdata=0xDEADBEEF, PREADY=1 -> PSEL at t+1, PENABLE at t+2, rsp_valid at t+3 with rsp_err=0, rsp_rdata=0.
2. Read, 3 wait states: PREADY low 3 ACCESS cycles, PRDATA=0x12345678 -> PADDR/PWRITE held stable; rsp_rdata=0x12345678 one cycle after PREADY.
3. Back-to-back: write then read, cmd_valid held -> PSEL never drops; SETUP follows ACCESS directly; two rsp_valid pulses 2 cycles apart.
4. Error: read with PSLVERR=1 at completion -> rsp_err=1. PSLVERR=1 during wait states does not complete the transfer.
5. Reset mid-ACCESS: rst=0 while PREADY=0 -> next edge PSEL=0, PENABLE=0, no rsp_valid; the next command starts cleanly.
6. Timeout (macro on, TIMEOUT_CYCLES=16): PREADY held 0 -> abort after 16 ACCESS cycles, rsp_err=1, PSEL=0. With the macro off, the requester is still in ACCESS after 100 cycles.
